// File: rtl/uart_rx_param_if.sv
// Serial-line / parallel-frame bundle for uart_rx_param.
// master drives the line and watches the frame outputs; slave is the receiver.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 data_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output data_in,
    input  data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  data_in,
    output data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input logic             uart_clk,
  input logic             rst,
  uart_rx_param_if.slave  rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  // The third sample lands one cycle past centre, so every decision slips by one.
  localparam int START_LAST = CLKS_PER_BIT / 2;
`else
  localparam int START_LAST = CLKS_PER_BIT / 2 - 1;
`endif
  localparam logic [CNT_W-1:0] START_END = CNT_W'(START_LAST);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_d;

  logic [DATA_BITS-1:0] data_out_q;
  logic                 data_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;

  logic sync1_q, sync2_q, rx_prev_q;
  logic fall;
  logic sample;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
`ifdef UART_RX_MAJORITY_EN
  logic rx_prev2_q;

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_prev2_q <= 1'b1;
    end else begin
      sync1_q    <= rx.data_in;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      rx_prev2_q <= rx_prev_q;
    end
  end

  assign sample = (sync2_q & rx_prev_q) | (sync2_q & rx_prev2_q) | (rx_prev_q & rx_prev2_q);
`else
  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx.data_in;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign sample = sync2_q;
`endif

  assign fall = rx_prev_q & ~sync2_q;

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == START_END) begin
          if (sample) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_cnt_d = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shreg_d = {sample, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          perr_d  = (PARITY_MODE == 1) ? ~(^shreg_q ^ sample) : (^shreg_q ^ sample);
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (!sample) ferr_d = 1'b1;
          // Leave on the last stop-bit centre so a start edge in the next half bit is caught.
          if (bit_cnt_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      data_valid_q <= done_d;
      // Frame outputs change only at completion, together with the valid strobe.
      if (done_d) begin
        data_out_q   <= shreg_q;
        parity_err_q <= perr_d;
        frame_err_q  <= ferr_d;
      end
    end
  end

  assign rx.data_out   = data_out_q;
  assign rx.data_valid = data_valid_q;
  assign rx.parity_err = parity_err_q;
  assign rx.frame_err  = frame_err_q;
  assign rx.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three receivers (8N1, 8E1, 8N2) at 16 clocks per bit.
// Expected values are hand-computed; line changes on falling clock edges.
module tb_uart_rx_param;

  localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int BUSY_FRAME  = 153;
  localparam int BUSY_GLITCH = 9;
  localparam logic [7:0] MAJ_EXP = 8'h00;
`else
  localparam int BUSY_FRAME  = 152;
  localparam int BUSY_GLITCH = 8;
  localparam logic [7:0] MAJ_EXP = 8'h04;
`endif

  logic uart_clk = 1'b0;
  logic rst      = 1'b1;
  logic line     = 1'b1;
  int   sel      = 0;

  always #5 uart_clk = ~uart_clk;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_p ();
  uart_rx_param_if #(.DATA_BITS(8)) if_s ();

  assign if_a.data_in = (sel == 0) ? line : 1'b1;
  assign if_p.data_in = (sel == 1) ? line : 1'b1;
  assign if_s.data_in = (sel == 2) ? line : 1'b1;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
    .uart_clk(uart_clk), .rst(rst), .rx(if_a.slave));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_p (
    .uart_clk(uart_clk), .rst(rst), .rx(if_p.slave));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_s (
    .uart_clk(uart_clk), .rst(rst), .rx(if_s.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame monitor: counts valid strobes and captures what came with them.
  int         vc[3] = '{0, 0, 0};
  logic [7:0] last_d[3];
  logic       last_pe[3];
  logic       last_fe[3];
  logic [7:0] hist_a[$];
  int         busy_cyc = 0;

  always @(negedge uart_clk) begin
    if (if_a.data_valid) begin
      vc[0]++; last_d[0] = if_a.data_out; last_pe[0] = if_a.parity_err; last_fe[0] = if_a.frame_err;
      hist_a.push_back(if_a.data_out);
    end
    if (if_p.data_valid) begin
      vc[1]++; last_d[1] = if_p.data_out; last_pe[1] = if_p.parity_err; last_fe[1] = if_p.frame_err;
    end
    if (if_s.data_valid) begin
      vc[2]++; last_d[2] = if_s.data_out; last_pe[2] = if_s.parity_err; last_fe[2] = if_s.frame_err;
    end
    if (if_a.busy) busy_cyc++;
  end

  task automatic hold(input logic v, input int n);
    line = v;
    repeat (n) @(negedge uart_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par,
                            input int nstop, input logic s2);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    if (has_par) hold(par, CPB);
    hold(1'b1, CPB);
    if (nstop == 2) hold(s2, CPB);
    line = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, b0, n;

    repeat (3) @(negedge uart_clk);
    check("rst_data_out",   32'(if_a.data_out), 32'h0);
    check("rst_data_valid", 32'(if_a.data_valid), 32'h0);
    check("rst_parity_err", 32'(if_a.parity_err), 32'h0);
    check("rst_frame_err",  32'(if_a.frame_err), 32'h0);
    check("rst_busy",       32'(if_a.busy), 32'h0);
    rst = 1'b0;
    hold(1'b1, 8);

    // 8N1 0xA5
    sel = 0; v0 = vc[0]; b0 = busy_cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1);
    hold(1'b1, 4);
    check("a5_valid_cnt", vc[0] - v0, 1);
    check("a5_data",      32'(last_d[0]), 32'hA5);
    check("a5_perr",      32'(last_pe[0]), 32'h0);
    check("a5_ferr",      32'(last_fe[0]), 32'h0);
    check("a5_busy_cyc",  busy_cyc - b0, BUSY_FRAME);
    check("a5_hold_data", 32'(if_a.data_out), 32'hA5);
    check("a5_valid_low", 32'(if_a.data_valid), 32'h0);

    // Even parity: 0x07 has three ones
    sel = 1;
    send_frame(8'h07, 1'b1, 1'b1, 1, 1'b1);
    hold(1'b1, 4);
    check("par_ok_cnt",  vc[1], 1);
    check("par_ok_data", 32'(last_d[1]), 32'h07);
    check("par_ok_perr", 32'(last_pe[1]), 32'h0);
    send_frame(8'h07, 1'b1, 1'b0, 1, 1'b1);
    hold(1'b1, 4);
    check("par_bad_cnt",  vc[1], 2);
    check("par_bad_data", 32'(last_d[1]), 32'h07);
    check("par_bad_perr", 32'(last_pe[1]), 32'h1);

    // 4-cycle false start
    sel = 0; v0 = vc[0]; b0 = busy_cyc;
    hold(1'b0, 4);
    hold(1'b1, 16);
    check("glitch_no_valid", vc[0] - v0, 0);
    check("glitch_busy_cyc", busy_cyc - b0, BUSY_GLITCH);
    check("glitch_busy_now", 32'(if_a.busy), 32'h0);

    // Two stop bits
    sel = 2;
    send_frame(8'h3C, 1'b0, 1'b0, 2, 1'b1);
    hold(1'b1, 4);
    check("stop2_ok_data", 32'(last_d[2]), 32'h3C);
    check("stop2_ok_ferr", 32'(last_fe[2]), 32'h0);
    send_frame(8'h3C, 1'b0, 1'b0, 2, 1'b0);
    hold(1'b1, 4);
    check("stop2_bad_cnt",  vc[2], 2);
    check("stop2_bad_data", 32'(last_d[2]), 32'h3C);
    check("stop2_bad_ferr", 32'(last_fe[2]), 32'h1);

    // Back-to-back frames with no idle gap
    sel = 0; v0 = vc[0];
    send_frame(8'h55, 1'b0, 1'b0, 1, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b0, 1, 1'b1);
    hold(1'b1, 4);
    n = hist_a.size();
    check("b2b_cnt", vc[0] - v0, 2);
    if (n >= 2) begin
      check("b2b_first",  32'(hist_a[n-2]), 32'h55);
      check("b2b_second", 32'(hist_a[n-1]), 32'hAA);
    end

    // Reset in the middle of data bit 4
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(1'b1, CPB);
    hold(1'b0, 8);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_data_out",   32'(if_a.data_out), 32'h0);
    check("mid_rst_data_valid", 32'(if_a.data_valid), 32'h0);
    check("mid_rst_parity_err", 32'(if_a.parity_err), 32'h0);
    check("mid_rst_frame_err",  32'(if_a.frame_err), 32'h0);
    check("mid_rst_busy",       32'(if_a.busy), 32'h0);
    check("mid_rst_p_perr",     32'(if_p.parity_err), 32'h0);
    line = 1'b1;
    repeat (3) @(negedge uart_clk);
    rst = 1'b0;
    hold(1'b1, 20);
    v0 = vc[0];
    send_frame(8'h81, 1'b0, 1'b0, 1, 1'b1);
    hold(1'b1, 4);
    check("post_rst_cnt",  vc[0] - v0, 1);
    check("post_rst_data", 32'(last_d[0]), 32'h81);
    check("post_rst_ferr", 32'(last_fe[0]), 32'h0);

    // 0x00 with a one-cycle high blip at the centre of bit 2
    v0 = vc[0];
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b0, 8);
    hold(1'b1, 1);
    hold(1'b0, 7);
    for (int i = 3; i < 8; i++) hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, 4);
    check("centre_glitch_cnt",  vc[0] - v0, 1);
    check("centre_glitch_data", 32'(last_d[0]), 32'(MAJ_EXP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 / 9600-baud receiver in the mp3player control path.
- Takes the asynchronous serial line and delivers parallel frames with a one-cycle valid strobe.
- Configurable data width, parity mode and stop-bit count.
- Adds false-start rejection, parity/framing error reporting and a busy indicator.

Parameters:
- CLKS_PER_BIT, 10417, uart_clk cycles per bit (9600 baud at 100 MHz); legal range >= 8.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- uart_clk  input  1  receiver clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  1  serial line; idles high; asynchronous to uart_clk.
- data_out  output  DATA_BITS  last received frame, LSB first on the wire.
- data_valid  output  1  one-cycle pulse; data_out and error flags valid with it.
- parity_err  output  1  parity mismatch on the frame flagged by data_valid.
- frame_err  output  1  a stop bit was sampled low on the frame flagged by data_valid.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - Synchroniser flops = 1; state = IDLE; counters = 0.
- Input path:
  - 2-flop synchroniser, then one edge-history flop.
  - Falling edge = previous synchronised value 1 and current synchronised value 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a falling edge go to START and clear the baud counter.
- START:
  - Baud counter counts 0..CLKS_PER_BIT/2-1 (integer divide), then the line is sampled.
  - Sample = 1: glitch; return to IDLE with no output activity.
  - Sample = 0: go to DATA, clear the baud counter and the bit counter.
- Bit sampling (DATA, PARITY, STOP):
  - Baud counter wraps at CLKS_PER_BIT-1.
  - Each bit is sampled on the wrap cycle, which is bit centre.
- DATA:
  - Sample n is written to data_out[n], n = 0..DATA_BITS-1, into a shift/holding register.
  - After bit DATA_BITS-1, go to PARITY if PARITY_MODE != 0, else go to STOP.
- PARITY:
  - Compute XOR of the data bits and the parity bit.
  - Odd mode: error when the XOR = 0. Even mode: error when the XOR = 1.
  - The result is held internally until the frame completes.
- STOP:
  - Sample STOP_BITS stop bits; any 0 sets the internal frame flag.
  - On the final stop sample, return to IDLE directly without waiting for the end of the bit, so a following start edge in the remaining half-bit is caught.
- Completion:
  - On the cycle after the final stop sample: data_valid = 1 for exactly one cycle.
  - In that same cycle, data_out, parity_err and frame_err are updated together.
  - data_valid pulses even when an error flag is set.
- Hold behaviour:
  - data_out and the error flags hold their values until the next completion.
  - data_out is never partially updated mid-frame; an internal shift register is used.
- parity_err stays 0 when PARITY_MODE = 0.
- busy = 1 from the cycle START is entered until the cycle IDLE is re-entered.
- Falling edges seen outside IDLE are ignored.
- A line held low (break) gives a frame_err completion, then IDLE. No new frame starts until the line returns high and falls again.
- Reset asserted mid-frame: immediate return to IDLE; outputs go to their reset values; the partial frame is discarded.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every bit (start, data, parity, stop) is decided by a 2-of-3 majority of samples at centre-1, centre and centre+1.
  - All decisions, state transitions and data_valid move one cycle later than without the macro.
  - A single-cycle glitch at centre is rejected.
- Undefined: single sample at bit centre as described above; no extra logic.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5 -> data_valid pulses once; data_out = 0xA5; parity_err = 0; frame_err = 0; busy high for about 9.5 bit times.
- PARITY_MODE=2, send 0x07 with parity bit 1 -> no error. Resend 0x07 with parity bit 0 -> parity_err = 1, data_out = 0x07.
- 4-cycle low pulse on an idle line -> no data_valid; busy returns to 0 within 9 cycles.
- STOP_BITS=2, send 0x3C with second stop bit 0 -> frame_err = 1, data_valid = 1.
- Back-to-back frames 0x55 then 0xAA with no idle gap -> two data_valid pulses with the correct data each.
- Assert rst during bit 4 of a frame -> all outputs 0 at once. Next clean frame 0x81 -> received correctly.
- UART_RX_MAJORITY_EN defined: 1-cycle inversion at centre of bit 2 of 0x00 -> data_out = 0x00. Without the macro -> data_out = 0x04.
